// File: rtl/ch_bank_scanner_pkg.sv
// Shared definitions for the CH memory bank, its scanner, writer and routing logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ch_bank_scanner_pkg;

    localparam int MEM_DEPTH  = 32;              // bank depth in bytes
    localparam int WORD_WIDTH = 16;              // {ch_id, q_value}
    localparam int ID_WIDTH   = 8;
    localparam int Q_WIDTH    = 8;

    localparam int N_ENTRIES  = MEM_DEPTH / 2;   // 16-bit entries in the bank
    localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
    localparam int K_WIDTH    = $clog2(N_ENTRIES);
    localparam int CNT_WIDTH  = K_WIDTH + 1;     // must hold 0..N_ENTRIES

    localparam logic [ID_WIDTH-1:0]  CH_EMPTY_ID = '0;
    localparam logic [CNT_WIDTH-1:0] MAX_COUNT   = CNT_WIDTH'(N_ENTRIES);

    // Field positions inside a bank word.
    localparam int CH_ID_MSB = 15;
    localparam int CH_ID_LSB = 8;
    localparam int CH_Q_MSB  = 7;
    localparam int CH_Q_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FINISH = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [Q_WIDTH-1:0]  q;
    } ch_word_t;

    // Requested entry counts above the bank size scan the whole bank.
    function automatic logic [CNT_WIDTH-1:0] clamp_count(input logic [CNT_WIDTH-1:0] cnt);
        return (cnt > MAX_COUNT) ? MAX_COUNT : cnt;
    endfunction

endpackage

// File: rtl/ch_bank_scanner_if.sv
// Bank read port plus CH-entry valid/ready stream between scanner and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: ent_ready stalls the entry stream; the bank port never stalls.
// Signals: mem_index/mem_wr_en/mem_data (bank), ent_valid/ent_id/ent_q/ent_ready (stream).
interface ch_bank_scanner_if;
    import ch_bank_scanner_pkg::*;

    logic [IDX_WIDTH-1:0]  mem_index;
    logic                  mem_wr_en;
    logic [WORD_WIDTH-1:0] mem_data;

    logic                  ent_valid;
    logic [ID_WIDTH-1:0]   ent_id;
    logic [Q_WIDTH-1:0]    ent_q;
    logic                  ent_ready;

    // master: the scanner; slave: bank + downstream consumer side.
    modport master (
        output mem_index, mem_wr_en, ent_valid, ent_id, ent_q,
        input  mem_data, ent_ready
    );

    modport slave (
        input  mem_index, mem_wr_en, ent_valid, ent_id, ent_q,
        output mem_data, ent_ready
    );

endinterface

// File: rtl/ch_bank_scanner_argmax.sv
// Running max register tracking the highest-Q CH entry seen since the last clear.
// Latency: result visible 1 cycle after load_en.
// Backpressure: none; load_en is sampled every cycle.
// Ports: clk, nrst, clear, load_en, id, q -> found, best_id, best_q.
module ch_argmax_reg
    import ch_bank_scanner_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                clear,
    input  logic                load_en,
    input  logic [ID_WIDTH-1:0] id,
    input  logic [Q_WIDTH-1:0]  q,
    output logic                found,
    output logic [ID_WIDTH-1:0] best_id,
    output logic [Q_WIDTH-1:0]  best_q
);

    // Strict compare: an equal Q arriving later never displaces the earlier entry.
    // The first candidate always loads, even with Q=0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            found   <= 1'b0;
            best_id <= '0;
            best_q  <= '0;
        end else if (clear) begin
            found   <= 1'b0;
            best_id <= '0;
            best_q  <= '0;
        end else if (load_en && (!found || (q > best_q))) begin
            found   <= 1'b1;
            best_id <= id;
            best_q  <= q;
        end
    end

endmodule

// File: rtl/ch_bank_scanner.sv
// Walks the CH bank on start, forwards non-empty entries and selects the max-Q entry.
// Latency: start->first read 1 cycle; empty entry 1 cycle; non-empty >=2; last entry->done 1.
// Backpressure: ent_ready low holds the scan in EMIT with entry data frozen, any length.
// Ports: clk, nrst, start, ch_count, bus (master), busy, done, found, best_id, best_q.
module ch_bank_scanner
    import ch_bank_scanner_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] ch_count,
    ch_bank_scanner_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [ID_WIDTH-1:0]  best_id,
    output logic [Q_WIDTH-1:0]   best_q
);

    scan_state_t          state;
    logic [K_WIDTH-1:0]   k;            // current entry number
    logic [CNT_WIDTH-1:0] n;            // entries to scan, latched at start
    logic [IDX_WIDTH-1:0] mem_index_q;
    logic                 ent_valid_q;
    ch_word_t             ent_word_q;

    ch_word_t             rd_word;
    logic                 rd_empty;
    logic                 last_entry;
    logic                 advance;
    logic                 scan_clear;
    logic                 best_load;
    logic [CNT_WIDTH-1:0] n_start;

    assign rd_word.id = bus.mem_data[CH_ID_MSB:CH_ID_LSB];
    assign rd_word.q  = bus.mem_data[CH_Q_MSB:CH_Q_LSB];
    assign rd_empty   = (rd_word.id == CH_EMPTY_ID);

    // n >= 1 whenever this is consulted (READ/EMIT only), so n-1 never wraps.
    assign last_entry = ({1'b0, k} == (n - CNT_WIDTH'(1)));

    // Leaving the current entry: either it was empty, or its handshake completed.
    assign advance    = ((state == ST_READ) && rd_empty) ||
                        ((state == ST_EMIT) && bus.ent_ready);

    assign scan_clear = (state == ST_IDLE) && start;
    assign best_load  = (state == ST_READ) && !rd_empty;
    assign n_start    = clamp_count(ch_count);

    assign bus.mem_index = mem_index_q;
    assign bus.mem_wr_en = 1'b0;
    assign bus.ent_valid = ent_valid_q;
    assign bus.ent_id    = ent_word_q.id;
    assign bus.ent_q     = ent_word_q.q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            k           <= '0;
            n           <= '0;
            mem_index_q <= '0;
            ent_valid_q <= 1'b0;
            ent_word_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_index_q <= '0;
                    if (start) begin
                        n <= n_start;
                        k <= '0;
                        if (n_start == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // Captured even when empty; only a non-empty word is presented.
                    ent_word_q <= rd_word;
                    if (!rd_empty) begin
                        state       <= ST_EMIT;
                        ent_valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (bus.ent_ready) begin
                        ent_valid_q <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Shared step to the next entry or to FINISH; overrides the case above.
            if (advance) begin
                if (last_entry) begin
                    state       <= ST_FINISH;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    mem_index_q <= '0;
                end else begin
                    state       <= ST_READ;
                    k           <= k + 1'b1;
                    mem_index_q <= {k + 1'b1, 1'b0};
                end
            end
        end
    end

    ch_argmax_reg u_argmax (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (scan_clear),
        .load_en (best_load),
        .id      (rd_word.id),
        .q       (rd_word.q),
        .found   (found),
        .best_id (best_id),
        .best_q  (best_q)
    );

endmodule

// File: doc/ch_bank_scanner.md
Name: ch_bank_scanner

Overview:
Read-side sequencer for the cluster-head (CH) memory bank. On a start pulse it walks the bank's 16-bit CH entries and forwards each non-empty entry over a valid/ready stream. It also selects the entry with the highest Q-value. It sits between the 32-byte CH memory bank (byte-indexed, 16-bit words at index/index+1, combinational read) and the routing/transmit logic that consumes the CH list and the best-hop decision.

Parameters:
MEM_DEPTH, 32, bank depth in bytes; entries = MEM_DEPTH/2 = 16
WORD_WIDTH, 16, bank word width; word = {ch_id[15:8], q_value[7:0]}
ID_WIDTH, 8, CH node ID width; ID 0 means empty slot
Q_WIDTH, 8, Q-value width, unsigned

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  synchronous active-low reset
start  in  1  one-cycle scan request; honoured only when busy=0
ch_count  in  5  number of entries to scan (0..16; values >16 clamp to 16)
mem_index  out  5  byte index to bank; entry k at index 2k
mem_wr_en  out  1  bank write enable; tied 0 (read-only master)
mem_data  in  16  bank read data, combinational from mem_index
ent_valid  out  1  forwarded entry valid
ent_id  out  8  forwarded entry CH ID
ent_q  out  8  forwarded entry Q-value
ent_ready  in  1  downstream accepts entry when ent_valid & ent_ready
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end
found  out  1  at least one non-empty entry seen in last scan
best_id  out  8  ID of max-Q entry from last scan
best_q  out  8  Q of max-Q entry from last scan

Behaviour:
- Clock: all state updates on rising clk. Reset: sync, active-low, applied when nrst=0 at a rising edge.
- Reset values: state=IDLE, k=0, mem_index=0, mem_wr_en=0, ent_valid=0, ent_id=0, ent_q=0, busy=0, done=0, found=0, best_id=0, best_q=0.
- FSM states: IDLE, READ, EMIT, FINISH.
- IDLE: mem_index=0. On start=1: latch n=min(ch_count,16), clear found/best_*, k=0.
  - If n=0, go to FINISH. Otherwise go to READ.
- READ (1 cycle per entry): mem_index=2k. The bank word is captured into ent_id/ent_q at the clock edge.
  - If mem_data[15:8]!=0: update best, then go to EMIT.
  - If mem_data[15:8]=0: skip. If k=n-1, go to FINISH; else k++ and stay in READ.
- Best update rule: when found=0 or q>best_q (strict), set best_id/best_q and found=1. Ties keep the lower index.
- EMIT: ent_valid=1, and ent_id/ent_q are held stable until the handshake.
  - On ent_ready=1: ent_valid drops next cycle. If k=n-1, go to FINISH; else k++ and go to READ.
  - ent_ready is ignored outside EMIT. Backpressure of any length is allowed.
- FINISH: done=1 for exactly 1 cycle, then IDLE. busy=0 in this cycle.
- busy=1 in READ and EMIT only.
- Latency:
  - start to first READ: 1 cycle.
  - Empty entry: 1 cycle.
  - Non-empty entry: 2 cycles minimum (ent_ready=1).
  - Last entry to done: 1 cycle.
- best_id/best_q/found hold after done until the next accepted start.
- start while busy, or in FINISH: ignored, no queuing.
- mem_index arithmetic: 2k fits 5 bits (max 30). The bank reads index+1 internally; index 31 is never driven.
- Reset mid-scan (any state): immediate return to reset values. No done pulse, and any pending entry is dropped.
- mem_data is sampled only in READ. Bank writes by other masters during a scan are not coherent; the scan uses whatever is read at each READ cycle.

Decomposition:
- Shared package: MEM_DEPTH, WORD_WIDTH, ID_WIDTH, Q_WIDTH, CH_EMPTY_ID=0, FSM state encoding (2-bit), and CH-word field slice positions. These are shared with the bank writer and routing logic.
- Optional sub-module: ch_argmax_reg, a running max register (clear, load_en, id, q -> found, best_id, best_q).
- FSM and index counter stay in the top.

Test Plan:
1. Bank words at entries 0..3 = 0x0510,0x0740,0x0320,0x0940; ch_count=4; ent_ready=1.
   - Expected: 4 handshakes (05/10, 07/40, 03/20, 09/40) and done at cycle 9 after start.
   - Expected result: found=1, best_id=0x07, best_q=0x40 (tie keeps lower index).
2. Entries 0,1,2 = 0x0000,0x0A05,0x0000; ch_count=3.
   - Expected: only 0x0A/0x05 emitted; mem_index sequence 0,2,4.
   - Expected result: best_id=0x0A, found=1.
3. ch_count=0, start.
   - Expected: done pulses the cycle after start; busy never set; found=0, best_id=0, best_q=0.
4. ch_count=20 with all 16 entries non-empty (IDs 1..16, Q=ID*3).
   - Expected: scan clamps to 16 entries; last mem_index=30; best_id=0x10, best_q=0x30.
5. Backpressure: hold ent_ready=0 for 5 cycles on the first entry.
   - Expected: ent_valid and data stable for all 5 cycles; a second start in that window is ignored; scan completes normally.
6. Drive nrst=0 for one cycle while in EMIT of entry 2.
   - Expected: all outputs return to reset values next cycle; no done pulse.
   - Expected: a fresh start rescans from mem_index=0.
